// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control sequencer: fetch/decode/execute/memory/writeback stepping,
// ALU select and datapath enables, memory handshake and retired-instruction count.
module mips_control_fsm #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic [2:0]         alu_select,
    output logic               alu_src_b,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               pc_write,
    output logic               pc_src,
    output logic               illegal,
    output logic [3:0]         state,
    output logic [COUNT_W-1:0] retired_count
);

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_R     = 4'd7,
        ST_WB_I     = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_BEQ = 3'b101;
    localparam logic [2:0] ALU_J   = 3'b110;

    state_t             state_r;
    state_t             state_s;
    logic [5:0]         op_q;
    logic [5:0]         fn_q;
    logic [COUNT_W-1:0] count_r;
    logic               illegal_r;
    logic               retire_s;

    function automatic logic r_funct_ok(input logic [5:0] fn);
        case (fn)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110: r_funct_ok = 1'b1;
            default:                                               r_funct_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b100110: r_alu = ALU_XOR;
            default:   r_alu = ALU_ADD;
        endcase
    endfunction

    function automatic logic [2:0] i_alu(input logic [5:0] op);
        case (op)
            6'b001100: i_alu = ALU_AND;
            6'b001101: i_alu = ALU_OR;
            6'b001110: i_alu = ALU_XOR;
            default:   i_alu = ALU_ADD;
        endcase
    endfunction

    // Next-state selection and retire strobe
    always_comb begin
        state_s  = state_r;
        retire_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (mem_ready) state_s = ST_DECODE;
                else           state_s = ST_FETCH;
            end
            ST_DECODE: begin
                case (opcode)
                    6'b000000: begin
                        if (r_funct_ok(funct)) state_s = ST_EXEC_R;
                        else                   state_s = ST_TRAP;
                    end
                    6'b001000, 6'b001100, 6'b001101, 6'b001110: state_s = ST_EXEC_I;
                    6'b100011, 6'b101011:                       state_s = ST_MEM_ADDR;
                    6'b000100:                                  state_s = ST_BRANCH;
                    6'b000010:                                  state_s = ST_JUMP;
                    default:                                    state_s = ST_TRAP;
                endcase
            end
            ST_EXEC_R: state_s = ST_WB_R;
            ST_EXEC_I: state_s = ST_WB_I;
            ST_MEM_ADDR: begin
                if (op_q == 6'b100011) state_s = ST_MEM_RD;
                else                   state_s = ST_MEM_WR;
            end
            ST_MEM_RD: begin
                if (mem_ready) state_s = ST_WB_MEM;
                else           state_s = ST_MEM_RD;
            end
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_s  = ST_FETCH;
                    retire_s = 1'b1;
                end else begin
                    state_s  = ST_MEM_WR;
                end
            end
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: begin
                state_s  = ST_FETCH;
                retire_s = 1'b1;
            end
            ST_TRAP: state_s = ST_TRAP;
            default: state_s = ST_TRAP;
        endcase
    end

    // State, latched instruction fields, retire counter and sticky illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_FETCH;
            op_q      <= 6'd0;
            fn_q      <= 6'd0;
            count_r   <= {COUNT_W{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_r == ST_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            if (retire_s) count_r <= count_r + COUNT_W'(1);
            if (state_s == ST_TRAP) illegal_r <= 1'b1;
        end
    end

    // Control decode from state; ir_write and the sw-completion pc_write follow mem_ready
    always_comb begin
        alu_select = ALU_ADD;
        alu_src_b  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        illegal    = 1'b0;
        if (rst) begin
            alu_select = 3'b000;
        end else begin
            illegal = illegal_r;
            case (state_r)
                ST_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                end
                ST_EXEC_R: alu_select = r_alu(fn_q);
                ST_EXEC_I: begin
                    alu_select = i_alu(op_q);
                    alu_src_b  = 1'b1;
                end
                ST_MEM_ADDR: alu_src_b = 1'b1;
                ST_MEM_RD:   mem_read  = 1'b1;
                ST_MEM_WR: begin
                    mem_write = 1'b1;
                    pc_write  = mem_ready;
                end
                ST_WB_R: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    pc_write  = 1'b1;
                end
                ST_WB_I: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                end
                ST_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    pc_write   = 1'b1;
                end
                ST_BRANCH: begin
                    alu_select = ALU_BEQ;
                    pc_write   = 1'b1;
                    pc_src     = 1'b1;
                end
                ST_JUMP: begin
                    alu_select = ALU_J;
                    pc_write   = 1'b1;
                    pc_src     = 1'b1;
                end
                default: alu_select = ALU_ADD;
            endcase
        end
    end

    assign state         = state_r;
    assign retired_count = count_r;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Self-checking bench for mips_control_fsm: a per-instruction cycle plan built from
// the instruction class drives mem_ready/opcode and predicts every output each cycle.
module tb_mips_control_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    opcode = 6'd0;
    logic [5:0]    funct = 6'd0;
    logic          mem_ready = 1'b0;
    logic [2:0]    alu_select;
    logic          alu_src_b, mem_read, mem_write, ir_write, reg_write;
    logic          reg_dst, mem_to_reg, pc_write, pc_src, illegal;
    logic [3:0]    state;
    logic [CW-1:0] retired_count;

    mips_control_fsm #(.COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .alu_select(alu_select), .alu_src_b(alu_src_b), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_write(pc_write),
        .pc_src(pc_src), .illegal(illegal), .state(state), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] NONE = 10'b00_0000_0000;
    localparam logic [9:0] SRCB = 10'b10_0000_0000;
    localparam logic [9:0] MRD  = 10'b01_0000_0000;
    localparam logic [9:0] MWR  = 10'b00_1000_0000;
    localparam logic [9:0] IRW  = 10'b00_0100_0000;
    localparam logic [9:0] RW   = 10'b00_0010_0000;
    localparam logic [9:0] RDST = 10'b00_0001_0000;
    localparam logic [9:0] M2R  = 10'b00_0000_1000;
    localparam logic [9:0] PCW  = 10'b00_0000_0100;
    localparam logic [9:0] PCS  = 10'b00_0000_0010;
    localparam logic [9:0] ILL  = 10'b00_0000_0001;
    localparam logic [2:0] ADD  = 3'b010;

    typedef struct {
        logic [3:0] st;
        logic [2:0] alu;
        logic [9:0] fl;
        logic       mr;
        logic [5:0] op;
        logic [5:0] fn;
        logic       ret;
    } step_t;

    step_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    mcount = 0;

    logic [5:0] op_tab [9] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001110,
                               6'b100011, 6'b101011, 6'b000100, 6'b000010};
    logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110};

    // instruction class: 0 R, 1 I, 2 lw, 3 sw, 4 beq, 5 j, 6 illegal
    function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) begin
            for (int i = 0; i < 5; i++) if (fn == fn_tab[i]) return 0;
            return 6;
        end
        if (op == 6'b001000 || op == 6'b001100 || op == 6'b001101 || op == 6'b001110) return 1;
        if (op == 6'b100011) return 2;
        if (op == 6'b101011) return 3;
        if (op == 6'b000100) return 4;
        if (op == 6'b000010) return 5;
        return 6;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
        logic [5:0] key;
        key = (op == 6'b000000) ? fn : op;
        case (key)
            6'b100000, 6'b001000: return 3'b010;
            6'b100010:            return 3'b011;
            6'b100100, 6'b001100: return 3'b000;
            6'b100101, 6'b001101: return 3'b001;
            default:              return 3'b100;
        endcase
    endfunction

    function automatic void push(input int st, input logic [2:0] alu, input logic [9:0] fl,
                                 input logic mr, input logic ret);
        step_t s;
        s.st  = 4'(st);
        s.alu = alu;
        s.fl  = fl;
        s.mr  = mr;
        s.op  = 6'($urandom);
        s.fn  = 6'($urandom);
        s.ret = ret;
        q.push_back(s);
    endfunction

    function automatic void plan_head(input logic [5:0] op, input logic [5:0] fn, input int fs);
        for (int i = 0; i < fs; i++) push(0, ADD, MRD, 1'b0, 1'b0);
        push(0, ADD, MRD | IRW, 1'b1, 1'b0);
        push(1, ADD, NONE, 1'($urandom), 1'b0);
        q[q.size()-1].op = op;
        q[q.size()-1].fn = fn;
    endfunction

    function automatic void plan(input logic [5:0] op, input logic [5:0] fn,
                                 input int fs, input int ms, input int trap_cyc);
        plan_head(op, fn, fs);
        case (kind(op, fn))
            0: begin
                push(2, alu_of(op, fn), NONE, 1'($urandom), 1'b0);
                push(7, ADD, RW | RDST | PCW, 1'($urandom), 1'b1);
            end
            1: begin
                push(3, alu_of(op, fn), SRCB, 1'($urandom), 1'b0);
                push(8, ADD, RW | PCW, 1'($urandom), 1'b1);
            end
            2: begin
                push(4, ADD, SRCB, 1'($urandom), 1'b0);
                for (int i = 0; i < ms; i++) push(5, ADD, MRD, 1'b0, 1'b0);
                push(5, ADD, MRD, 1'b1, 1'b0);
                push(9, ADD, RW | M2R | PCW, 1'($urandom), 1'b1);
            end
            3: begin
                push(4, ADD, SRCB, 1'($urandom), 1'b0);
                for (int i = 0; i < ms; i++) push(6, ADD, MWR, 1'b0, 1'b0);
                push(6, ADD, MWR | PCW, 1'b1, 1'b1);
            end
            4: push(10, 3'b101, PCW | PCS, 1'($urandom), 1'b1);
            5: push(11, 3'b110, PCW | PCS, 1'($urandom), 1'b1);
            default: for (int i = 0; i < trap_cyc; i++) push(12, ADD, ILL, 1'($urandom), 1'b0);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] ctl();
        return {alu_select, alu_src_b, mem_read, mem_write, ir_write, reg_write,
                reg_dst, mem_to_reg, pc_write, pc_src, illegal};
    endfunction

    // Drive each planned cycle from a negedge and compare just after
    task automatic run_q();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            mem_ready = s.mr;
            opcode    = s.op;
            funct     = s.fn;
            #1;
            check("state", 32'(state), 32'(s.st));
            check("ctl", 32'(ctl()), 32'({s.alu, s.fl}));
            check("count", 32'(retired_count), 32'(mcount));
            @(negedge clk);
            if (s.ret) mcount = (mcount + 1) % (1 << CW);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'($urandom);
        #1;
        check("rst_ctl", 32'(ctl()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mcount = 0;
    endtask

    initial begin
        logic [5:0] op, fn;
        @(negedge clk);
        do_reset();

        // add with mem_ready high: states 0,1,2,7 then next fetch
        plan(6'b000000, 6'b100000, 0, 0, 0);
        run_q();
        check("add_retired", 32'(retired_count), 32'd1);

        // lw with three MEM_RD stall cycles
        plan(6'b100011, 6'd0, 0, 3, 0);
        run_q();

        // beq then j back to back
        plan(6'b000100, 6'd0, 0, 0, 0);
        plan(6'b000010, 6'd0, 0, 0, 0);
        run_q();
        check("bj_retired", 32'(retired_count), 32'd4);

        // illegal opcode, then illegal funct, each cleared by reset
        plan(6'b111111, 6'd0, 1, 0, 12);
        run_q();
        do_reset();
        plan(6'b000000, 6'b000000, 0, 0, 11);
        run_q();
        do_reset();
        check("trap_cleared", 32'(illegal), 32'd0);

        // reset during the MEM_WR wait
        plan(6'b001101, 6'd0, 0, 0, 0);
        plan_head(6'b101011, 6'd0, 0);
        push(4, ADD, SRCB, 1'b0, 1'b0);
        push(6, ADD, MWR, 1'b0, 1'b0);
        push(6, ADD, MWR, 1'b0, 1'b0);
        run_q();
        mem_ready = 1'b0;
        #1;
        check("sw_wait_state", 32'(state), 32'd6);
        check("sw_wait_mw", 32'(mem_write), 32'd1);
        do_reset();
        plan(6'b000000, 6'b100010, 0, 0, 0);
        run_q();

        // counter wrap at 2^CW
        do_reset();
        for (int i = 0; i < 15; i++) plan(6'b000000, 6'b100000, 0, 0, 0);
        run_q();
        check("count_max", 32'(retired_count), 32'd15);
        plan(6'b001000, 6'd0, 0, 0, 0);
        run_q();
        check("count_wrap", 32'(retired_count), 32'd0);

        // randomized instruction stream with random stalls
        for (int n = 0; n < 200; n++) begin
            op = op_tab[$urandom_range(0, 8)];
            fn = (op == 6'b000000) ? fn_tab[$urandom_range(0, 4)] : 6'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            plan(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), 3);
            run_q();
            if (kind(op, fn) == 6) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
